// File: rtl/div_tick_gen_pkg.sv
// div_tick_gen_pkg: constants shared by the divider lookup table and the tick generator
package div_tick_gen_pkg;
    localparam int DIV_WIDTH = 7;
    localparam int DIV_RST   = 83;
    typedef enum logic [2:0] {
        SPD_30, SPD_50, SPD_75, SPD_100, SPD_125, SPD_150, SPD_175, SPD_200
    } speed_e;
    function automatic logic [DIV_WIDTH-1:0] div_for(speed_e s);
        return s == SPD_30  ? 7'd83 :
               s == SPD_50  ? 7'd50 :
               s == SPD_75  ? 7'd33 :
               s == SPD_100 ? 7'd25 :
               s == SPD_125 ? 7'd20 :
               s == SPD_150 ? 7'd17 :
               s == SPD_175 ? 7'd14 : 7'd13;
    endfunction
endpackage

// File: rtl/div_tick_gen_if.sv
// div_tick_gen_if: ratio-in / tick-out bus between divider lookup and tick generator
//   i_ce      base-rate enable pulse from the prescaler
//   i_en      run enable; 0 freezes counting
//   i_numdiv  requested divide ratio
//   o_tick    one-clock pulse at each period end
//   o_sq_out  near-50% square wave at the tick rate
//   o_upd     pulse when a different ratio is adopted
//   o_div_err high while the active ratio is 0
interface div_tick_gen_if
    import div_tick_gen_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             i_ce;
    logic             i_en;
    logic [WIDTH-1:0] i_numdiv;
    logic             o_tick;
    logic             o_sq_out;
    logic             o_upd;
    logic             o_div_err;
    modport master (output i_ce, i_en, i_numdiv, input  o_tick, o_sq_out, o_upd, o_div_err);
    modport slave  (input  i_ce, i_en, i_numdiv, output o_tick, o_sq_out, o_upd, o_div_err);
endinterface

// File: rtl/div_tick_gen.sv
// div_tick_gen: divides ce pulses by a shadowed ratio into a tick pulse and a square wave
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    div_tick_gen_if slave: ce/en/numdiv in, tick/sq_out/upd/div_err out
module div_tick_gen
    import div_tick_gen_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int RST_DIV = DIV_RST
) (
    input  logic          clock,
    input  logic          reset,
    div_tick_gen_if.slave bus
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic             r_tick;
    logic             r_sq;
    logic             r_upd;
    logic             r_div_err;
    logic             w_run;
    logic             w_zero;
    logic             w_bound;
    logic             w_load;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_half;

    assign w_run        = bus.i_en & bus.i_ce;
    assign w_zero       = r_shadow == '0;
    assign w_bound      = w_run & ~w_zero & (r_cnt == r_shadow - 1'b1);
    // A zero ratio reloads on every counted ce so a valid ratio is picked up at once
    assign w_load       = w_bound | (w_run & w_zero);
    assign w_shadow_nxt = w_load ? bus.i_numdiv : r_shadow;
    assign w_cnt_nxt    = (w_bound | w_zero) ? '0 : w_run ? r_cnt + 1'b1 : r_cnt;
    // ceil(D/2) without widening: D=127 gives 64, still in range
    assign w_half       = (w_shadow_nxt >> 1) + {{(WIDTH-1){1'b0}}, w_shadow_nxt[0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_shadow  <= WIDTH'(RST_DIV);
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
            r_upd     <= 1'b0;
            r_div_err <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_tick   <= w_bound;
            r_upd    <= w_load & (bus.i_numdiv != r_shadow);
            // Compare against the value the counter is about to hold so the wave is aligned to it
            if (w_run) begin
                r_sq      <= w_cnt_nxt < w_half;
                r_div_err <= w_shadow_nxt == '0;
            end
        end
    end

    assign bus.o_tick    = r_tick;
    assign bus.o_sq_out  = r_sq;
    assign bus.o_upd     = r_upd;
    assign bus.o_div_err = r_div_err;
endmodule

// File: tb/tb_div_tick_gen.sv
// tb_div_tick_gen: directed self-checking bench for div_tick_gen
module tb_div_tick_gen;
    import div_tick_gen_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ce_div = 1;
    int   ce_ph = 0;

    div_tick_gen_if bus();
    div_tick_gen dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1(output int c);
        c = (ce_ph == ce_div - 1) ? 1 : 0;
        ce_ph = c != 0 ? 0 : ce_ph + 1;
        bus.i_ce = c != 0;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tick(input int limit, output int ces, output int clks, output int u, output int hi);
        int c;
        ces = 0; clks = 0; u = 0; hi = 0;
        while (clks < limit) begin
            clk1(c);
            clks++;
            ces += c;
            hi += int'(bus.o_sq_out);
            if (bus.o_tick) begin
                u = int'(bus.o_upd);
                return;
            end
        end
        ces = -1;
    endtask

    initial begin
        int ces, clks, u, hi, c, nt;
        bus.i_ce = 1'b0;
        bus.i_en = 1'b1;
        bus.i_numdiv = 7'd83;
        #12;
        check("rst_outputs", int'({bus.o_tick, bus.o_sq_out, bus.o_upd, bus.o_div_err}), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick(200, ces, clks, u, hi);
            check("d83_period", ces, 83);
            check("d83_sq_high", hi, 42);
            check("d83_upd", u, 0);
        end
        bus.i_numdiv = 7'd13;
        wait_tick(200, ces, clks, u, hi);
        check("to13_period", ces, 83);
        check("to13_upd", u, 1);
        wait_tick(200, ces, clks, u, hi);
        check("d13_period", ces, 13);
        check("d13_sq_high", hi, 7);
        check("d13_upd", u, 0);
        repeat (5) clk1(c);
        bus.i_numdiv = 7'd25;
        wait_tick(200, ces, clks, u, hi);
        check("mid_change_rest", ces, 8);
        check("mid_change_upd", u, 1);
        wait_tick(200, ces, clks, u, hi);
        check("d25_period", ces, 25);
        check("d25_upd", u, 0);
        ce_div = 3;
        ce_ph = 0;
        bus.i_numdiv = 7'd1;
        wait_tick(200, ces, clks, u, hi);
        check("to1_period", ces, 25);
        check("to1_upd", u, 1);
        for (int i = 0; i < 2; i++) begin
            wait_tick(10, ces, clks, u, hi);
            check("d1_ces", ces, 1);
            check("d1_clks", clks, 3);
            check("d1_sq_high", hi, 3);
        end
        ce_div = 1;
        ce_ph = 0;
        bus.i_numdiv = 7'd0;
        wait_tick(10, ces, clks, u, hi);
        check("to0_period", ces, 1);
        check("to0_upd", u, 1);
        check("zero_err", int'(bus.o_div_err), 1);
        check("zero_sq", int'(bus.o_sq_out), 0);
        nt = 0;
        repeat (6) begin
            clk1(c);
            nt += int'(bus.o_tick) + int'(bus.o_upd) + int'(bus.o_sq_out);
        end
        check("zero_quiet", nt, 0);
        check("zero_err_hold", int'(bus.o_div_err), 1);
        bus.i_numdiv = 7'd20;
        clk1(c);
        check("recover_err", int'(bus.o_div_err), 0);
        check("recover_upd", int'(bus.o_upd), 1);
        wait_tick(100, ces, clks, u, hi);
        check("d20_first", ces, 20);
        check("d20_upd", u, 0);
        bus.i_numdiv = 7'd17;
        wait_tick(100, ces, clks, u, hi);
        check("to17_period", ces, 20);
        repeat (7) clk1(c);
        bus.i_en = 1'b0;
        nt = 0;
        hi = 0;
        repeat (10) begin
            clk1(c);
            nt += int'(bus.o_tick);
            hi += int'(bus.o_sq_out);
        end
        check("en0_ticks", nt, 0);
        check("en0_sq_hold", hi, 10);
        bus.i_en = 1'b1;
        wait_tick(100, ces, clks, u, hi);
        check("en_resume", ces, 10);
        repeat (16) clk1(c);
        bus.i_en = 1'b0;
        clk1(c);
        check("en_prio_tick", int'(bus.o_tick), 0);
        bus.i_en = 1'b1;
        clk1(c);
        check("en_prio_after", int'(bus.o_tick), 1);
        bus.i_numdiv = 7'd50;
        wait_tick(100, ces, clks, u, hi);
        check("to50_period", ces, 17);
        repeat (30) clk1(c);
        check("d50_c30_sq", int'(bus.o_sq_out), 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mid", int'({bus.o_tick, bus.o_sq_out, bus.o_upd, bus.o_div_err}), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_tick(200, ces, clks, u, hi);
        check("post_rst_period", ces, 83);
        check("post_rst_upd", u, 1);
        check("pre_rst_sq", int'(bus.o_sq_out), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_clear", int'({bus.o_tick, bus.o_sq_out, bus.o_upd}), 0);
        #1;
        reset = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
